// File: rtl/multi_breathing_light_if.sv
// -----------------------------------------------------------------------------
// multi_breathing_light_if
// Control/status bundle between the board switch inputs and the breathing
// light controller.
//   en     : 1 = phase generator advances, 0 = phase frozen
//   speed  : step-period select (0 slowest .. 3 fastest)
//   mode   : per-channel mode, bits [2i+1:2i]: 00 off, 01 on, 10 breathe, 11 blink
//   light  : registered LED drive, 1 = lit
//   sync   : single-cycle pulse when the master phase wraps to 0
// No handshake: en/speed/mode are level controls sampled every clk;
// light/sync are registered outputs valid every cycle.
// -----------------------------------------------------------------------------
interface multi_breathing_light_if #(
  parameter int CH = 4
);
  logic            en;
  logic [1:0]      speed;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   light;
  logic            sync;

  modport master (output en, speed, mode, input light, sync);
  modport slave  (input en, speed, mode, output light, sync);
endinterface

// File: rtl/multi_breathing_light.sv
// -----------------------------------------------------------------------------
// multi_breathing_light
// Multi-channel breathing-light controller. A shared step counter advances a
// master phase; each channel sees that phase offset by i*(2^P/CH), folds it
// into a triangle and squares it for a gamma-like duty. A free-running PWM
// counter turns duty into on-time; duty is only reloaded at frame end so every
// PWM frame is glitch-free.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : multi_breathing_light_if.slave (en, speed, mode in; light, sync out)
// -----------------------------------------------------------------------------
module multi_breathing_light #(
  parameter int CH     = 4,
  parameter int PWM_W  = 8,
  parameter int STEP_W = 26,
  parameter int STEP0  = 600000,
  parameter int STEP1  = 300000,
  parameter int STEP2  = 150000,
  parameter int STEP3  = 75000
) (
  input  logic                     clk,
  input  logic                     rst,
  multi_breathing_light_if.slave   bus
);

  localparam int P  = PWM_W + 1;      // master phase width
  localparam int PW = 2 * PWM_W + 1;  // gamma product width

  localparam logic [PWM_W-1:0] PWM_MAX   = '1;
  localparam logic [P-1:0]     PHASE_MAX = '1;

  typedef logic [PW-1:0] prod_t;

  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_lim;
  logic [P-1:0]      phase;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [CH-1:0]     light_q;
  logic [CH-1:0]     light_d;
  logic              sync_q;
  logic              step_wrap;

  // Limit is STEP(speed)-1.
  always_comb begin
    step_lim = '0;
    case (bus.speed)
      2'd0:    step_lim = STEP_W'(STEP0 - 1);
      2'd1:    step_lim = STEP_W'(STEP1 - 1);
      2'd2:    step_lim = STEP_W'(STEP2 - 1);
      default: step_lim = STEP_W'(STEP3 - 1);
    endcase
  end

  // >= rather than ==: lowering the step period while step_cnt is already
  // past the new limit wraps on the next cycle instead of counting through
  // the whole STEP_W range.
  assign step_wrap = (step_cnt >= step_lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= '0;
      phase    <= '0;
      pwm_cnt  <= '0;
      light_q  <= '0;
      sync_q   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      light_q <= light_d;
      // sync is high exactly in the cycle where phase reads 0 after a wrap.
      sync_q  <= bus.en && step_wrap && (phase == PHASE_MAX);
      if (bus.en) begin
        if (step_wrap) begin
          step_cnt <= '0;
          phase    <= phase + 1'b1;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam logic [P-1:0] OFS = P'(i * ((2 ** P) / CH));

    logic [P-1:0]     ph;
    logic [PWM_W-1:0] tri_v;
    prod_t            prod;
    logic [PWM_W-1:0] gam;
    logic [PWM_W-1:0] duty;
    logic             lit;

    assign ph    = phase + OFS;
    assign tri_v = ph[P-1] ? ~ph[PWM_W-1:0] : ph[PWM_W-1:0];
    // tri*(tri+1) >> PWM_W: 0 at tri=0, full scale at tri max.
    assign prod  = prod_t'(tri_v) * (prod_t'(tri_v) + prod_t'(1));
    assign gam   = prod[2*PWM_W-1:PWM_W];

    // Reload only on the last count of a frame so the new duty starts cleanly.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        duty <= '0;
      end else if (pwm_cnt == PWM_MAX) begin
        duty <= gam;
      end
    end

    always_comb begin
      lit = 1'b0;
      case (bus.mode[2*i +: 2])
        2'b00:   lit = 1'b0;
        2'b01:   lit = 1'b1;
        2'b10:   lit = (pwm_cnt < duty);
        default: lit = ph[P-1];
      endcase
    end

    assign light_d[i] = lit;
  end

  assign bus.light = light_q;
  assign bus.sync  = sync_q;

endmodule
